ex_stage_md: RTL and testbench

EX_STAGE_MD -- requirements
Module: ex_stage_md

---
 rtl/ex_pkg.sv | 80 ++++++++
 rtl/md_unit.sv | 161 ++++++++++++++++
 rtl/ex_stage_md.sv | 129 ++++++++++++
 tb/tb_ex_stage_md.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute stage: multiply/divide FSM state type and
// encodings, RV M-extension funct3/funct7 codes, ALU operation classes,
// forwarding selects and the ALU control decode helper.
// -----------------------------------------------------------------------------
package ex_pkg;

   // Multiply/divide sequencer states (plain constants keep the encoding
   // stable for older tools and waveform decoders).
   typedef logic [1:0] md_state_t;
   localparam md_state_t MD_IDLE = 2'd0;
   localparam md_state_t MD_BUSY = 2'd1;
   localparam md_state_t MD_DONE = 2'd2;

   // funct7 values of interest
   localparam logic [6:0] FUNCT7_M   = 7'b0000001;
   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   // M-extension funct3 codes
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // alu_op classes from the decoder
   localparam logic [1:0] ALU_OP_ADD    = 2'b00;  // loads/stores/address calc
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;  // compare by subtraction
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;  // register-register
   localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;  // register-immediate

   // Forwarding selects (11 falls back to the register value)
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // ALU control codes
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_ctrl_t;

   // alt is funct7[5]: selects SUB (register form only) and SRA/SRAI.
   function automatic alu_ctrl_t alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] funct3,
                                            input logic       alt);
      alu_ctrl_t ctrl;
      ctrl = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD:    ctrl = ALU_ADD;
         ALU_OP_BRANCH: ctrl = ALU_SUB;
         default: begin
            case (funct3)
               3'b000:  ctrl = (alu_op == ALU_OP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
               3'b001:  ctrl = ALU_SLL;
               3'b010:  ctrl = ALU_SLT;
               3'b011:  ctrl = ALU_SLTU;
               3'b100:  ctrl = ALU_XOR;
               3'b101:  ctrl = alt ? ALU_SRA : ALU_SRL;
               3'b110:  ctrl = ALU_OR;
               default: ctrl = ALU_AND;
            endcase
         end
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Iterative RV M-extension unit: shift-add multiply and restoring divide, one
// bit per cycle, sharing one pair of XLEN-bit working registers.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   flush            abandon any operation, return to IDLE next cycle
//   start            a live M-op is present in EX this cycle
//   funct3           M-op selector
//   op_a, op_b       forwarded rs1 / rs2 values
//   stall            hold the pipeline while the operation is in flight
//   done             result register is valid (DONE state)
//   result           registered M result
// -----------------------------------------------------------------------------
module md_unit
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int               CNT_W     = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   // Two's-complement sign fix-up applied to magnitudes.
   function automatic logic [XLEN-1:0] cond_neg(input logic neg,
                                                input logic [XLEN-1:0] v);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic neg,
                                                       input logic [2*XLEN-1:0] v);
      return neg ? (~v + (2*XLEN)'(1)) : v;
   endfunction

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3_q;
   logic             neg_a_q;
   logic             neg_b_q;
   logic [XLEN-1:0]  opnd_q;    // multiplicand (mul) or divisor (div) magnitude
   logic [XLEN-1:0]  hi_q;      // product high half / partial remainder
   logic [XLEN-1:0]  lo_q;      // multiplier->product low half / dividend->quotient
   logic [XLEN-1:0]  result_q;

   // Acceptance-time operand conditioning
   logic            is_div, a_signed, b_signed, neg_a, neg_b, div_zero;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      is_div   = funct3[2];
      a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
      b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
      neg_a    = a_signed & op_a[XLEN-1];
      neg_b    = b_signed & op_b[XLEN-1];
      mag_a    = cond_neg(neg_a, op_a);
      mag_b    = cond_neg(neg_b, op_b);
      div_zero = is_div & (op_b == '0);
   end

   // One iteration of the multiply or divide recurrence
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [XLEN-1:0]   hi_nxt, lo_nxt, res_nxt;
   logic [2*XLEN-1:0] prod_fix;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (f3_q[2]) begin
         // Restore (keep the shifted remainder) when the trial subtract goes negative.
         if (!div_diff[XLEN]) begin
            hi_nxt = div_diff[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = div_shift[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
      end

      // Final value, only captured on the last iteration. The remainder
      // follows the dividend sign; everything else follows sign(a)^sign(b).
      prod_fix = cond_neg_wide(neg_a_q ^ neg_b_q, {hi_nxt, lo_nxt});
      case (f3_q)
         F3_MUL:                       res_nxt = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: res_nxt = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              res_nxt = cond_neg(neg_a_q ^ neg_b_q, lo_nxt);
         default:                      res_nxt = cond_neg(neg_a_q, hi_nxt);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         f3_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else if (flush) begin
         state <= MD_IDLE;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  f3_q    <= funct3;
                  neg_a_q <= neg_a;
                  neg_b_q <= neg_b;
                  opnd_q  <= is_div ? mag_b : mag_a;
                  lo_q    <= is_div ? mag_a : mag_b;
                  hi_q    <= '0;
                  cnt     <= '0;
                  if (div_zero) begin
                     // Divide by zero needs no iterations.
                     result_q <= funct3[1] ? op_a : '1;
                     state    <= MD_DONE;
                  end else begin
                     state <= MD_BUSY;
                  end
               end
            end
            MD_BUSY: begin
               hi_q <= hi_nxt;
               lo_q <= lo_nxt;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_ITER) begin
                  result_q <= res_nxt;
                  state    <= MD_DONE;
               end
            end
            MD_DONE: state <= MD_IDLE;
            default: state <= MD_IDLE;
         endcase
      end
   end

   // Flush and reset drop the stall in the same cycle so the pipeline can
   // move on immediately.
   assign stall  = ~reset & ~flush &
                   ((state == MD_BUSY) | ((state == MD_IDLE) & start));
   assign done   = (state == MD_DONE);
   assign result = result_q;

endmodule

// File: rtl/ex_stage_md.sv
// -----------------------------------------------------------------------------
// ex_stage_md
// RV32 execute stage: operand forwarding, single-cycle base ALU, branch target
// adder and an optional iterative multiply/divide unit that stalls the front
// of the pipeline while it works.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   imm_ex, reg_data1_ex,
//   reg_data2_ex, pc_ex         immediate, rs1, rs2, instruction PC
//   funct3_ex, funct7_ex,
//   alu_op_ex, alu_src_ex       decode controls (alu_src_ex=1 selects imm)
//   forward_a, forward_b        00 register, 01 WB, 10 MEM (11 = register)
//   alu_data_wb, alu_data_mem   forwarded results
//   valid_ex, flush_ex          live instruction / kill instruction
//   zero_ex, alu_out_ex         result and result==0
//   pc_branch_ex                pc_ex + imm_ex
//   reg_data2_final_ex          forwarded rs2 (store data)
//   stall_ex                    freeze IF/ID/EX, bubble into MEM
// -----------------------------------------------------------------------------
module ex_stage_md
   import ex_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int MD_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] imm_ex,
   input  logic [XLEN-1:0] reg_data1_ex,
   input  logic [XLEN-1:0] reg_data2_ex,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [2:0]      funct3_ex,
   input  logic [6:0]      funct7_ex,
   input  logic [1:0]      alu_op_ex,
   input  logic            alu_src_ex,
   input  logic [1:0]      forward_a,
   input  logic [1:0]      forward_b,
   input  logic [XLEN-1:0] alu_data_wb,
   input  logic [XLEN-1:0] alu_data_mem,
   input  logic            valid_ex,
   input  logic            flush_ex,
   output logic            zero_ex,
   output logic [XLEN-1:0] alu_out_ex,
   output logic [XLEN-1:0] pc_branch_ex,
   output logic [XLEN-1:0] reg_data2_final_ex,
   output logic            stall_ex
);

   localparam int SH_W = $clog2(XLEN);

   logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
   logic [SH_W-1:0] shamt;
   alu_ctrl_t       alu_ctrl;
   logic            m_op;
   logic            md_stall, md_done;
   logic [XLEN-1:0] md_result;

   // Operand forwarding
   always_comb begin
      case (forward_a)
         FWD_WB:  fwd_a = alu_data_wb;
         FWD_MEM: fwd_a = alu_data_mem;
         default: fwd_a = reg_data1_ex;
      endcase
      case (forward_b)
         FWD_WB:  fwd_b = alu_data_wb;
         FWD_MEM: fwd_b = alu_data_mem;
         default: fwd_b = reg_data2_ex;
      endcase
   end

   assign op_b               = alu_src_ex ? imm_ex : fwd_b;
   assign reg_data2_final_ex = fwd_b;
   assign pc_branch_ex       = pc_ex + imm_ex;

   // Base ALU
   assign alu_ctrl = alu_decode(alu_op_ex, funct3_ex, funct7_ex[5]);
   assign shamt    = op_b[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         ALU_ADD:  alu_res = fwd_a + op_b;
         ALU_SUB:  alu_res = fwd_a - op_b;
         ALU_SLL:  alu_res = fwd_a << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
         ALU_XOR:  alu_res = fwd_a ^ op_b;
         ALU_SRL:  alu_res = fwd_a >> shamt;
         ALU_SRA:  alu_res = XLEN'($signed(fwd_a) >>> shamt);
         ALU_OR:   alu_res = fwd_a | op_b;
         ALU_AND:  alu_res = fwd_a & op_b;
         default:  alu_res = '0;
      endcase
   end

   // With MD_EN=0 an M-encoded instruction falls through to the base ALU.
   assign m_op = valid_ex && (alu_op_ex == ALU_OP_RTYPE) &&
                 (funct7_ex == FUNCT7_M) && (MD_EN != 0);

   generate
      if (MD_EN != 0) begin : g_md
         md_unit #(
            .XLEN (XLEN)
         ) u_md (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush_ex),
            .start  (m_op),
            .funct3 (funct3_ex),
            .op_a   (fwd_a),
            .op_b   (fwd_b),
            .stall  (md_stall),
            .done   (md_done),
            .result (md_result)
         );
      end else begin : g_no_md
         assign md_stall  = 1'b0;
         assign md_done   = 1'b0;
         assign md_result = '0;
      end
   endgenerate

   assign alu_out_ex = md_done ? md_result : alu_res;
   assign zero_ex    = (alu_out_ex == '0);
   assign stall_ex   = md_stall;

endmodule

// File: tb/tb_ex_stage_md.sv
module tb_ex_stage_md;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imm_ex, reg_data1_ex, reg_data2_ex, pc_ex;
   logic [2:0]  funct3_ex;
   logic [6:0]  funct7_ex;
   logic [1:0]  alu_op_ex;
   logic        alu_src_ex;
   logic [1:0]  forward_a, forward_b;
   logic [31:0] alu_data_wb, alu_data_mem;
   logic        valid_ex, flush_ex;
   logic        zero_ex, stall_ex;
   logic [31:0] alu_out_ex, pc_branch_ex, reg_data2_final_ex;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_stage_md #(.XLEN(32), .MD_EN(1)) dut (
      .clk                (clk),
      .reset              (reset),
      .imm_ex             (imm_ex),
      .reg_data1_ex       (reg_data1_ex),
      .reg_data2_ex       (reg_data2_ex),
      .pc_ex              (pc_ex),
      .funct3_ex          (funct3_ex),
      .funct7_ex          (funct7_ex),
      .alu_op_ex          (alu_op_ex),
      .alu_src_ex         (alu_src_ex),
      .forward_a          (forward_a),
      .forward_b          (forward_b),
      .alu_data_wb        (alu_data_wb),
      .alu_data_mem       (alu_data_mem),
      .valid_ex           (valid_ex),
      .flush_ex           (flush_ex),
      .zero_ex            (zero_ex),
      .alu_out_ex         (alu_out_ex),
      .pc_branch_ex       (pc_branch_ex),
      .reg_data2_final_ex (reg_data2_final_ex),
      .stall_ex           (stall_ex)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
      if (op == 2'b00) return a + b;
      if (op == 2'b01) return a - b;
      case (f3)
         3'd0:    return (op == 2'b10 && f7[5]) ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      imm_ex = 0; reg_data1_ex = 0; reg_data2_ex = 0; pc_ex = 0;
      funct3_ex = 0; funct7_ex = 0; alu_op_ex = 0; alu_src_ex = 0;
      forward_a = 0; forward_b = 0; alu_data_wb = 0; alu_data_mem = 0;
      valid_ex = 0; flush_ex = 0;
   endtask

   // Route a and b through randomly chosen forwarding paths.
   task automatic place_operands(input logic [31:0] a, input logic [31:0] b);
      forward_a = 2'($urandom_range(0, 3));
      forward_b = 2'($urandom_range(0, 3));
      if (forward_b == forward_a && (forward_a == 2'b01 || forward_a == 2'b10))
         forward_b = 2'b00;
      reg_data1_ex = $urandom; reg_data2_ex = $urandom;
      alu_data_wb  = $urandom; alu_data_mem = $urandom;
      case (forward_a)
         2'b01:   alu_data_wb  = a;
         2'b10:   alu_data_mem = a;
         default: reg_data1_ex = a;
      endcase
      case (forward_b)
         2'b01:   alu_data_wb  = b;
         2'b10:   alu_data_mem = b;
         default: reg_data2_ex = b;
      endcase
   endtask

   task automatic set_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      valid_ex = 1; alu_op_ex = 2'b10; funct7_ex = 7'b0000001; funct3_ex = f3;
      alu_src_ex = 0; imm_ex = $urandom; pc_ex = $urandom;
      place_operands(a, b);
   endtask

   // Issue one M-op, count stall cycles up to the result cycle, check, then
   // step once more and withdraw the instruction.
   task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_stalls);
      int n;
      set_mop(f3, a, b);
      settle();
      n = 0;
      while (stall_ex === 1'b1 && n < 100) begin
         n++;
         tick();
         reg_data1_ex = $urandom; reg_data2_ex = $urandom;
         alu_data_wb  = $urandom; alu_data_mem = $urandom;
         settle();
      end
      check({tag, " stalls"}, 32'(n), 32'(exp_stalls));
      check({tag, " result"}, alu_out_ex, exp_res);
      check({tag, " zero"}, {31'd0, zero_ex}, {31'd0, (exp_res == 32'd0)});
      tick();
      valid_ex = 0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] a, b, e;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [1:0]  op;

      clear_inputs();
      reset = 1;
      tick(); tick();
      settle();
      check("reset stall", {31'd0, stall_ex}, 32'd0);
      check("reset alu_out", alu_out_ex, 32'd0);
      check("reset zero", {31'd0, zero_ex}, 32'd1);

      // M-op presented while reset is held must not be accepted
      set_mop(3'd0, 32'd3, 32'd5);
      settle();
      check("reset over accept", {31'd0, stall_ex}, 32'd0);
      tick();
      clear_inputs();
      reset = 0;
      settle();
      check("no accept after reset", {31'd0, stall_ex}, 32'd0);

      // ADD 5+7 with rs1 forwarded from MEM (=3)
      valid_ex = 1; alu_op_ex = 2'b10; funct7_ex = 0; funct3_ex = 0;
      reg_data1_ex = 5; reg_data2_ex = 7; forward_a = 2'b10; alu_data_mem = 3;
      pc_ex = 32'h0000_1000; imm_ex = 32'h20;
      settle();
      check("fwd add result", alu_out_ex, 32'd10);
      check("fwd add stall", {31'd0, stall_ex}, 32'd0);
      check("fwd add rs2 final", reg_data2_final_ex, 32'd7);
      check("pc branch", pc_branch_ex, 32'h0000_1020);
      pc_ex = 32'hFFFF_FFF0;
      settle();
      check("pc branch wrap", pc_branch_ex, 32'h0000_0010);

      // M-encoded op with valid low runs as a base ALU op
      valid_ex = 0; funct7_ex = 7'b0000001; funct3_ex = 3'd0; forward_a = 0;
      reg_data1_ex = 32'd40; reg_data2_ex = 32'd2;
      settle();
      check("m enc invalid result", alu_out_ex, 32'd42);
      check("m enc invalid stall", {31'd0, stall_ex}, 32'd0);
      tick();

      // Random base ALU ops
      for (int i = 0; i < 24; i++) begin
         clear_inputs();
         op = 2'($urandom_range(0, 3));
         f3 = 3'($urandom_range(0, 7));
         f7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
         a = pick_val(); b = pick_val();
         valid_ex = 1'($urandom_range(0, 1));
         alu_op_ex = op; funct3_ex = f3; funct7_ex = f7;
         alu_src_ex = 1'($urandom_range(0, 1));
         imm_ex = $urandom; pc_ex = $urandom;
         place_operands(a, b);
         settle();
         e = ref_alu(op, f3, f7, a, alu_src_ex ? imm_ex : b);
         check("alu result", alu_out_ex, e);
         check("alu zero", {31'd0, zero_ex}, {31'd0, (e == 32'd0)});
         check("alu stall", {31'd0, stall_ex}, 32'd0);
         check("alu rs2 final", reg_data2_final_ex, b);
         check("alu pc branch", pc_branch_ex, pc_ex + imm_ex);
         tick();
      end
      clear_inputs();

      // Directed M-ops
      run_mop("mul", 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33);
      run_mop("mulhu", 3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33);
      run_mop("div neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_mop("rem neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_mop("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run_mop("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_mop("divu by0", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
      run_mop("remu by0", 3'd7, 32'd9, 32'd0, 32'd9, 1);

      // Random M-ops, back to back
      for (int i = 0; i < 14; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = pick_val(); b = pick_val();
         run_mop("rand mop", f3, a, b, ref_md(f3, a, b),
                 (f3[2] && b == 32'd0) ? 1 : 33);
      end

      // Flush has priority over acceptance
      clear_inputs();
      set_mop(3'd0, 32'd6, 32'd7);
      flush_ex = 1;
      settle();
      check("flush vs accept stall", {31'd0, stall_ex}, 32'd0);
      tick();
      clear_inputs();
      settle();
      check("flush vs accept idle", {31'd0, stall_ex}, 32'd0);

      // Flush at BUSY iteration 10, then an ADD goes through
      set_mop(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      settle();
      check("flush test accept", {31'd0, stall_ex}, 32'd1);
      tick();
      repeat (10) tick();
      check("flush test busy", {31'd0, stall_ex}, 32'd1);
      flush_ex = 1;
      tick();
      clear_inputs();
      valid_ex = 1; alu_op_ex = 2'b00; reg_data1_ex = 32'd20; reg_data2_ex = 32'd22;
      settle();
      check("after flush stall", {31'd0, stall_ex}, 32'd0);
      check("after flush add", alu_out_ex, 32'd42);
      tick();
      check("after flush stays idle", {31'd0, stall_ex}, 32'd0);
      clear_inputs();

      // Reset in the middle of a divide
      set_mop(3'd4, 32'd1000, 32'd7);
      settle();
      repeat (6) tick();
      check("reset test busy", {31'd0, stall_ex}, 32'd1);
      reset = 1;
      tick();
      check("mid reset stall", {31'd0, stall_ex}, 32'd0);
      clear_inputs();
      reset = 0;
      settle();
      check("post reset stall", {31'd0, stall_ex}, 32'd0);
      check("post reset alu_out", alu_out_ex, 32'd0);
      check("post reset zero", {31'd0, zero_ex}, 32'd1);
      run_mop("div after reset", 3'd4, 32'd1000, 32'd7, 32'd142, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
